// File: rtl/sound_event_arbiter_if.sv
// Event and request signals between Pong game logic and the sound-event arbiter.
interface sound_event_arbiter_if;
  logic       HitPaddle;
  logic       HitWall;
  logic       PointScored;
  logic       GameOver;
  logic       Mute;
  logic       PlayAgain;
  logic [1:0] Choice;
  logic       Busy;
  logic [3:0] Pending;

  modport master (
    output HitPaddle, HitWall, PointScored, GameOver, Mute,
    input  PlayAgain, Choice, Busy, Pending
  );

  modport slave (
    input  HitPaddle, HitWall, PointScored, GameOver, Mute,
    output PlayAgain, Choice, Busy, Pending
  );
endinterface

// File: rtl/sound_event_arbiter.sv
// Turns game event edges into stretched PlayAgain requests with a fixed-priority
// one-deep queue per event type and a Choice lockout after every request.
module sound_event_arbiter #(
  parameter int PulseCycles   = 1500000,
  parameter int LockoutCycles = 25000000,
  parameter int CounterBits   = 25
) (
  input  logic                 Clock,
  input  logic                 Reset,
  sound_event_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PULSE, LOCKOUT} state_t;

  localparam logic [CounterBits-1:0] PulseLast = CounterBits'(PulseCycles - 1);
  localparam logic [CounterBits-1:0] LockLast  = CounterBits'(LockoutCycles - 1);

  state_t                 state_q, state_d;
  logic [CounterBits-1:0] timer_q, timer_d;
  logic [1:0]             choice_q, choice_d;
  logic [3:0]             pend_q, pend_d;
  logic [3:0]             hist_q;
  logic [3:0]             evt_q, evt_d;
  logic                   armed_q;
  logic [3:0]             ev_in;
  logic [1:0]             grant_idx;
  logic [3:0]             grant_mask;

  assign ev_in = {bus.GameOver, bus.PointScored, bus.HitWall, bus.HitPaddle};

  // armed_q masks the first cycle after reset so levels already high never count as edges
  assign evt_d = (armed_q && !bus.Mute) ? (ev_in & ~hist_q) : 4'b0000;

  always_comb begin
    grant_idx = 2'd0;
    if (pend_q[3])      grant_idx = 2'd3;
    else if (pend_q[2]) grant_idx = 2'd2;
    else if (pend_q[1]) grant_idx = 2'd1;
  end

  assign grant_mask = 4'b0001 << grant_idx;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    choice_d = choice_q;
    pend_d   = pend_q | evt_q;
    unique case (state_q)
      IDLE: begin
        if (pend_q != 4'b0000 && !bus.Mute) begin
          state_d  = PULSE;
          timer_d  = '0;
          choice_d = grant_idx;
          pend_d   = pend_d & ~grant_mask;
        end
      end
      PULSE: begin
        if (timer_q == PulseLast) begin
          state_d = LOCKOUT;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      LOCKOUT: begin
        if (timer_q == LockLast) begin
          state_d = IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.Mute) pend_d = 4'b0000;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      choice_q <= 2'd0;
      pend_q   <= 4'b0000;
      hist_q   <= 4'b0000;
      evt_q    <= 4'b0000;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      choice_q <= choice_d;
      pend_q   <= pend_d;
      hist_q   <= ev_in;
      evt_q    <= evt_d;
      armed_q  <= 1'b1;
    end
  end

  assign bus.PlayAgain = (state_q == PULSE);
  assign bus.Busy      = (state_q != IDLE);
  assign bus.Choice    = choice_q;
  assign bus.Pending   = pend_q;

endmodule
